reaction_ctrl: RTL and testbench
================================

# reaction_ctrl

Sequencing controller for the reaction-time game. It consumes the 1 ms tick from the millisecond timer and drives the game round: a pseudo-random wait, then the GO lamp, then the reaction measurement in milliseconds. It flags false starts and timeouts. It sits between the debounced button inputs, the millisecond timer and the display/LED logic.

## Interface
- MAX_MS, default 9999: reaction ceiling in ms; a round times out at this count.
- MIN_WAIT_MS, default 1000: fixed part of the pre-GO wait, in ms.
- RAND_BITS, default 11: width of the random wait addend; addend range is 0..2^RAND_BITS-1 ms.
- LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
- clk  in  1: system clock.
- rst  in  1: asynchronous, active-high reset.
- msec_pulse  in  1: one-clk-wide tick, once per ms, from the millisecond timer.
- start_btn  in  1: debounced, synchronised start button, level.
- react_btn  in  1: debounced, synchronised reaction button, level.
- led_go  out  1: GO lamp; high only in state GO.
- busy  out  1: high in WAIT and GO.
- result_ms  out  RW: measured reaction in ms. RW = $clog2(MAX_MS+1).
- result_valid  out  1: high in DONE.
- false_start  out  1: high in FAULT.
- timeout  out  1: high in DONE when the round hit MAX_MS.

## Operation
- Edge detect:
  - start_e = start_btn & ~start_q; react_e = react_btn & ~react_q.
  - start_q and react_q reset to 1, so a button held through reset produces no edge.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk in all states, free-running.
- States: IDLE, WAIT, GO, DONE, FAULT.
- IDLE:
  - start_e → WAIT.
  - Load wait_tgt = MIN_WAIT_MS + lfsr[RAND_BITS-1:0], using the LFSR value in that cycle.
  - Clear ms_cnt.
- WAIT:
  - Each msec_pulse increments ms_cnt.
  - When ms_cnt == wait_tgt and msec_pulse is high → GO; clear ms_cnt.
  - react_e → FAULT. This takes priority over the GO transition in the same cycle.
  - start_e is ignored.
- GO:
  - Each msec_pulse increments ms_cnt.
  - react_e → DONE; result_ms = ms_cnt, the value before any same-cycle increment.
  - msec_pulse with ms_cnt == MAX_MS-1 and no react_e → DONE; timeout=1; result_ms = MAX_MS.
  - start_e is ignored.
- DONE and FAULT:
  - Outputs hold.
  - start_e behaves as in IDLE: load a new wait_tgt, clear ms_cnt, clear result_valid, false_start and timeout, go to WAIT.
  - result_ms holds its last value until the next DONE.
- ms_cnt:
  - Width is max(RW, $clog2(MIN_WAIT_MS+2^RAND_BITS)).
  - Never wraps: it is cleared on every state entry that uses it.
- All outputs are registered or decoded directly from the state register. No combinational input-to-output paths.

## Timing
- Reset values:
  - state=IDLE, ms_cnt=0, result_ms=0.
  - led_go=0, busy=0, result_valid=0, false_start=0, timeout=0.
  - lfsr=LFSR_SEED, start_q=1, react_q=1.
- Asynchronous reset mid-round aborts immediately to the reset values. No result is produced.
- Latency: a button rising at sampling edge N changes state and outputs at edge N. They are visible in cycle N+1.
- WAIT length: exactly wait_tgt+1 msec_pulse ticks after entry; led_go rises on the edge of the final tick.
- Reaction count: counts whole ms ticks between led_go rising and react_e. Sub-ms remainder is truncated.
- A button held continuously yields one edge. A re-press needs a low sample in between.
- msec_pulse has no effect outside WAIT and GO.

## Test plan
- Nominal round:
  - Stimulus: msec_pulse every 4 clk; MIN_WAIT_MS=3, RAND_BITS=2, LFSR_SEED forced so that the addend is 1; start pulse; react 7 ticks after led_go.
  - Required: busy=1 after start; led_go rises after 5 ticks; result_ms=7, result_valid=1, timeout=0.
- False start:
  - Stimulus: react_e during WAIT, including the cycle that coincides with the final wait tick.
  - Required: state FAULT, false_start=1, led_go never rises.
- Timeout:
  - Stimulus: MAX_MS=20; no react press.
  - Required: after 20 ticks in GO, result_ms=20, timeout=1, result_valid=1, led_go=0.
- Simultaneous react_e and msec_pulse in GO with ms_cnt=5:
  - Required: result_ms=5.
- Re-arm:
  - Stimulus: start from DONE and from FAULT.
  - Required: flags clear, WAIT is entered, new wait_tgt loaded; start_e inside WAIT/GO is ignored.
- Reset:
  - Stimulus: assert rst mid-GO.
  - Required: all outputs 0, IDLE next cycle.
  - Stimulus: hold react_btn high across reset release.
  - Required: no edge is registered.

Source files
------------

// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: random pre-GO wait, GO lamp, then reaction
// measurement in ms ticks, with false-start and timeout detection.
module reaction_ctrl #(
   parameter int          MAX_MS      = 9999,
   parameter int          MIN_WAIT_MS = 1000,
   parameter int          RAND_BITS   = 11,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           msec_pulse,
   input  logic                           start_btn,
   input  logic                           react_btn,
   output logic                           led_go,
   output logic                           busy,
   output logic [$clog2(MAX_MS+1)-1:0]    result_ms,
   output logic                           result_valid,
   output logic                           false_start,
   output logic                           timeout
);

   localparam int RW = $clog2(MAX_MS + 1);
   localparam int WW = $clog2(MIN_WAIT_MS + 2**RAND_BITS);
   localparam int CW = (RW > WW) ? RW : WW;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_GO    = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] ms_cnt_q, ms_cnt_d;
   logic [CW-1:0] wait_tgt_q, wait_tgt_d;
   logic [RW-1:0] result_q, result_d;
   logic          timeout_q, timeout_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic          start_q, react_q;
   logic          start_e, react_e;

   // Edge registers reset high so a button held through reset yields no edge.
   assign start_e = start_btn & ~start_q;
   assign react_e = react_btn & ~react_q;

   always_comb begin
      state_d    = state_q;
      ms_cnt_d   = ms_cnt_q;
      wait_tgt_d = wait_tgt_q;
      result_d   = result_q;
      timeout_d  = timeout_q;
      // Taps 16,14,13,11 in right-shifting Fibonacci form.
      lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      case (state_q)
         S_WAIT: begin
            if (react_e) begin
               state_d = S_FAULT;
            end else if (msec_pulse) begin
               if (ms_cnt_q == wait_tgt_q) begin
                  state_d  = S_GO;
                  ms_cnt_d = '0;
               end else begin
                  ms_cnt_d = ms_cnt_q + CW'(1);
               end
            end
         end
         S_GO: begin
            if (react_e) begin
               result_d = RW'(ms_cnt_q);
               state_d  = S_DONE;
            end else if (msec_pulse) begin
               if (ms_cnt_q == CW'(MAX_MS - 1)) begin
                  result_d  = RW'(MAX_MS);
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  ms_cnt_d = ms_cnt_q + CW'(1);
               end
            end
         end
         default: begin
            if (start_e) begin
               wait_tgt_d = CW'(MIN_WAIT_MS) + CW'(lfsr_q[RAND_BITS-1:0]);
               ms_cnt_d   = '0;
               timeout_d  = 1'b0;
               state_d    = S_WAIT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ms_cnt_q   <= '0;
         wait_tgt_q <= '0;
         result_q   <= '0;
         timeout_q  <= 1'b0;
         lfsr_q     <= LFSR_SEED;
         start_q    <= 1'b1;
         react_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         ms_cnt_q   <= ms_cnt_d;
         wait_tgt_q <= wait_tgt_d;
         result_q   <= result_d;
         timeout_q  <= timeout_d;
         lfsr_q     <= lfsr_d;
         start_q    <= start_btn;
         react_q    <= react_btn;
      end
   end

   assign led_go       = (state_q == S_GO);
   assign busy         = (state_q == S_WAIT) || (state_q == S_GO);
   assign result_valid = (state_q == S_DONE);
   assign false_start  = (state_q == S_FAULT);
   assign timeout      = timeout_q;
   assign result_ms    = result_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: directed rounds plus random buttons/ticks, all
// outputs compared every cycle against a round-level reference model.
module tb_reaction_ctrl;

   localparam int          MAX_MS      = 20;
   localparam int          MIN_WAIT_MS = 3;
   localparam int          RAND_BITS   = 2;
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;
   localparam int          RW          = $clog2(MAX_MS + 1);

   localparam int P_IDLE = 0, P_WAIT = 1, P_GO = 2, P_DONE = 3, P_FAULT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          msec_pulse = 1'b0;
   logic          start_btn = 1'b0;
   logic          react_btn = 1'b0;
   logic          led_go, busy, result_valid, false_start, timeout;
   logic [RW-1:0] result_ms;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int tick_mode = 0;

   // Reference model: round phase, ticks still owed before GO, ticks elapsed in GO.
   int          m_phase, m_remain, m_elapsed, m_result;
   bit          m_valid, m_fs, m_to, m_ps, m_pr, tick_at_edge;
   logic [15:0] m_lfsr;

   reaction_ctrl #(
      .MAX_MS(MAX_MS), .MIN_WAIT_MS(MIN_WAIT_MS),
      .RAND_BITS(RAND_BITS), .LFSR_SEED(LFSR_SEED)
   ) dut (
      .clk(clk), .rst(rst), .msec_pulse(msec_pulse),
      .start_btn(start_btn), .react_btn(react_btn),
      .led_go(led_go), .busy(busy), .result_ms(result_ms),
      .result_valid(result_valid), .false_start(false_start), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      int fb;
      fb = ((int'(l) >> 0) ^ (int'(l) >> 2) ^ (int'(l) >> 3) ^ (int'(l) >> 5)) & 1;
      return 16'((int'(l) >> 1) | (fb << 15));
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_remain = 0; m_elapsed = 0; m_result = 0;
      m_valid = 0; m_fs = 0; m_to = 0;
      m_ps = 1; m_pr = 1; m_lfsr = LFSR_SEED; tick_at_edge = 0;
   endtask

   task automatic model_update();
      bit se, re;
      int addend;
      se = start_btn && !m_ps;
      re = react_btn && !m_pr;
      m_ps = start_btn;
      m_pr = react_btn;
      tick_at_edge = msec_pulse;
      addend = int'(m_lfsr) % (1 << RAND_BITS);
      m_lfsr = lfsr_next(m_lfsr);
      case (m_phase)
         P_WAIT: begin
            if (re) begin
               m_phase = P_FAULT; m_fs = 1;
            end else if (msec_pulse) begin
               m_remain--;
               if (m_remain == 0) begin m_phase = P_GO; m_elapsed = 0; end
            end
         end
         P_GO: begin
            if (re) begin
               m_result = m_elapsed; m_valid = 1; m_phase = P_DONE;
            end else if (msec_pulse) begin
               if (m_elapsed + 1 == MAX_MS) begin
                  m_result = MAX_MS; m_to = 1; m_valid = 1; m_phase = P_DONE;
               end else begin
                  m_elapsed++;
               end
            end
         end
         default: begin
            if (se) begin
               m_remain = MIN_WAIT_MS + addend + 1;
               m_valid = 0; m_fs = 0; m_to = 0;
               m_phase = P_WAIT;
            end
         end
      endcase
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_update();
      @(negedge clk);
      check_eq("cyc_led_go", int'(led_go), int'(m_phase == P_GO));
      check_eq("cyc_busy", int'(busy), int'(m_phase == P_WAIT || m_phase == P_GO));
      check_eq("cyc_result_ms", int'(result_ms), m_result);
      check_eq("cyc_result_valid", int'(result_valid), int'(m_valid));
      check_eq("cyc_false_start", int'(false_start), int'(m_fs));
      check_eq("cyc_timeout", int'(timeout), int'(m_to));
      cyc++;
      if (tick_mode == 0) msec_pulse = (cyc % 4 == 3);
      else msec_pulse = ($urandom_range(0, 2) == 0);
   endtask

   task automatic wait_go(input string tag);
      for (int i = 0; i < 400 && !led_go; i++) step();
      check_eq(tag, int'(led_go), 1);
   endtask

   task automatic press_start();
      start_btn = 1'b0; step();
      start_btn = 1'b1; step();
      start_btn = 1'b0;
   endtask

   initial begin
      int n;
      model_reset();
      // Reset state
      repeat (3) step();
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_result_ms", int'(result_ms), 0);
      rst = 1'b0;
      step();

      // Nominal round with random addend 1 (wait_tgt = 4)
      for (int i = 0; i < 200 && (int'(m_lfsr) % 4) != 1; i++) step();
      check_eq("nom_addend_align", int'(m_lfsr) % 4, 1);
      start_btn = 1'b1; step();
      check_eq("nom_busy", int'(busy), 1);
      start_btn = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && !led_go; i++) begin
         step();
         if (tick_at_edge) n++;
      end
      check_eq("nom_wait_ticks", n, 5);
      check_eq("nom_led_go", int'(led_go), 1);
      n = 0;
      for (int i = 0; i < 200 && n < 7; i++) begin
         step();
         if (tick_at_edge) n++;
      end
      react_btn = 1'b1; step();
      check_eq("nom_result_ms", int'(result_ms), 7);
      check_eq("nom_valid", int'(result_valid), 1);
      check_eq("nom_timeout", int'(timeout), 0);
      check_eq("nom_led_off", int'(led_go), 0);
      react_btn = 1'b0; step();

      // Re-arm from DONE; start repress inside WAIT ignored; react coincident with tick at 5
      press_start();
      check_eq("rearm_done_valid", int'(result_valid), 0);
      check_eq("rearm_done_busy", int'(busy), 1);
      step();
      press_start();
      check_eq("wait_start_ignored", int'(busy), 1);
      wait_go("sim_go");
      n = 0;
      for (int i = 0; i < 200 && n < 5; i++) begin
         step();
         if (tick_at_edge) n++;
      end
      for (int i = 0; i < 8 && !msec_pulse; i++) step();
      react_btn = 1'b1; step();
      check_eq("sim_result_ms", int'(result_ms), 5);
      check_eq("sim_valid", int'(result_valid), 1);
      react_btn = 1'b0; step();

      // False start on the final wait tick
      press_start();
      for (int i = 0; i < 400 && !(m_phase == P_WAIT && m_remain == 1 && msec_pulse); i++) step();
      react_btn = 1'b1; step();
      check_eq("fs_final_flag", int'(false_start), 1);
      check_eq("fs_final_led", int'(led_go), 0);
      react_btn = 1'b0;
      repeat (10) step();
      check_eq("fs_led_stays_off", int'(led_go), 0);

      // Re-arm from FAULT, early false start
      press_start();
      check_eq("rearm_fault_flag", int'(false_start), 0);
      check_eq("rearm_fault_busy", int'(busy), 1);
      repeat (2) step();
      react_btn = 1'b1; step();
      check_eq("fs_early_flag", int'(false_start), 1);
      react_btn = 1'b0; step();

      // Timeout, with a start press inside GO
      press_start();
      wait_go("to_go");
      n = 0;
      for (int i = 0; i < 400 && !result_valid; i++) begin
         if (i == 10) start_btn = 1'b1;
         if (i == 12) start_btn = 1'b0;
         step();
         if (tick_at_edge) n++;
      end
      check_eq("to_ticks", n, 20);
      check_eq("to_result_ms", int'(result_ms), 20);
      check_eq("to_timeout", int'(timeout), 1);
      check_eq("to_led", int'(led_go), 0);

      // Asynchronous reset mid-GO, react held through release
      press_start();
      check_eq("to_rearm_timeout", int'(timeout), 0);
      wait_go("rst_go");
      repeat (3) step();
      react_btn = 1'b1;
      rst = 1'b1;
      #1;
      check_eq("arst_led", int'(led_go), 0);
      check_eq("arst_busy", int'(busy), 0);
      check_eq("arst_result_ms", int'(result_ms), 0);
      check_eq("arst_valid", int'(result_valid), 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (6) step();
      check_eq("held_react_fs", int'(false_start), 0);
      check_eq("held_react_busy", int'(busy), 0);
      react_btn = 1'b0; step();

      // Random buttons and ticks
      tick_mode = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
         if ($urandom_range(0, 9) == 0) react_btn = ~react_btn;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
